// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and types for the 4-slot TDM receiver
//   NUM_SLOTS   : slots per frame
//   SLOT_W      : width of the slot index
//   FRAME_CNT_W : width of the good-frame counter
//   tdm_state_t : frame FSM states (HUNT looks for a frame start, RUN tracks slots)
//   slot_t      : slot index type

package tdm_pkg;

    localparam int NUM_SLOTS   = 4;
    localparam int SLOT_W      = 2;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

    // Next slot index; the 2-bit index wraps 3 -> 0 naturally.
    function automatic slot_t slot_next(input slot_t s);
        return s + slot_t'(1);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - slot position counter for the TDM receiver
//   clk, reset : clock, asynchronous active-high reset
//   inc        : advance to the next slot (wraps after the last slot)
//   load1      : force slot 1 (a frame-start beat has just been taken as slot 0)
//   clr        : force slot 0
//   slot       : slot index expected for the next beat
//   last       : slot is the final slot of the frame

module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  inc,
    input  logic  load1,
    input  logic  clr,
    output slot_t slot,
    output logic  last
);

    slot_t slot_q;
    slot_t slot_d;

    // clr wins over load1, which wins over inc; the FSM never asserts
    // more than one, but a fixed priority keeps the counter well defined.
    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (load1) begin
            slot_d = slot_t'(1);
        end else if (inc) begin
            slot_d = slot_next(slot_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;
    assign last = (slot_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-channel TDM receive demultiplexer with framing check
//   clk, reset   : clock, asynchronous active-high reset
//   din          : multiplexed sample for the current slot
//   din_valid    : din/frame_start are meaningful this cycle (a beat)
//   frame_start  : beat is slot 0 of a frame
//   y0..y3       : channel samples of the last complete frame
//   frame_valid  : one-cycle pulse, y0..y3 just updated
//   slot         : slot index expected for the next beat
//   sync_err     : one-cycle pulse on a framing violation
//   frame_cnt    : count of complete frames, wraps

module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   frame_start,
    output logic [WIDTH-1:0]       y0,
    output logic [WIDTH-1:0]       y1,
    output logic [WIDTH-1:0]       y2,
    output logic [WIDTH-1:0]       y3,
    output logic                   frame_valid,
    output logic [SLOT_W-1:0]      slot,
    output logic                   sync_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    tdm_state_t state_q, state_d;

    // Staging for channels 0..2; channel 3 goes straight from din to y3.
    logic [WIDTH-1:0] stage_q [NUM_SLOTS-1];
    logic [WIDTH-1:0] stage_d [NUM_SLOTS-1];

    logic [WIDTH-1:0] y_q [NUM_SLOTS];
    logic [WIDTH-1:0] y_d [NUM_SLOTS];

    logic                   frame_valid_q, frame_valid_d;
    logic                   sync_err_q, sync_err_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic  slot_inc, slot_load1, slot_clr;
    slot_t cur_slot;
    logic  cur_last;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (slot_inc),
        .load1 (slot_load1),
        .clr   (slot_clr),
        .slot  (cur_slot),
        .last  (cur_last)
    );

    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        slot_inc      = 1'b0;
        slot_load1    = 1'b0;
        slot_clr      = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Beats without a frame start are dropped silently while hunting.
                    if (frame_start) begin
                        stage_d[0] = din;
                        slot_load1 = 1'b1;
                        state_d    = RUN;
                    end
                end

                RUN: begin
                    if (cur_slot == '0) begin
                        if (frame_start) begin
                            stage_d[0] = din;
                            slot_load1 = 1'b1;
                        end else begin
                            // Missing start: lose lock and go back to hunting.
                            sync_err_d = 1'b1;
                            slot_clr   = 1'b1;
                            state_d    = HUNT;
                        end
                    end else if (frame_start) begin
                        // Early start: drop the partial frame, this beat is the new slot 0.
                        // Published y values are left untouched.
                        sync_err_d = 1'b1;
                        stage_d[0] = din;
                        slot_load1 = 1'b1;
                    end else if (cur_last) begin
                        y_d[0]        = stage_q[0];
                        y_d[1]        = stage_q[1];
                        y_d[2]        = stage_q[2];
                        y_d[3]        = din;
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + FRAME_CNT_W'(1);
                        slot_clr      = 1'b1;
                    end else begin
                        unique case (cur_slot)
                            slot_t'(1): stage_d[1] = din;
                            slot_t'(2): stage_d[2] = din;
                            default:    stage_d[0] = din;
                        endcase
                        slot_inc = 1'b1;
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HUNT;
            stage_q       <= '{default: '0};
            y_q           <= '{default: '0};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign y0          = y_q[0];
    assign y1          = y_q[1];
    assign y2          = y_q[2];
    assign y3          = y_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign slot        = cur_slot;

endmodule
